// File: rtl/rat_recovery_walker_if.sv
// Signal bundle between the RAT recovery walker and its ROB / RAT / free-list neighbours.
// The master view belongs to the walker; the slave view belongs to the surrounding pipeline.
interface rat_recovery_walker_if #(
    parameter int unsigned ROB_IDX_W = 5,
    parameter int unsigned PHYS_W    = 6
);
    logic                 mispredict_valid;
    logic [ROB_IDX_W-1:0] mispredict_idx;
    logic [ROB_IDX_W-1:0] rob_tail;
    logic                 flush_valid;
    logic [ROB_IDX_W-1:0] rob_rd_idx;
    logic                 rob_rd_uses_rd;
    logic [4:0]           rob_rd_arch;
    logic [PHYS_W-1:0]    rob_rd_pd_old;
    logic [PHYS_W-1:0]    rob_rd_pd_new;
    logic                 recover_valid;
    logic [4:0]           recover_rd_arch;
    logic [PHYS_W-1:0]    recover_pd;
    logic                 free_valid;
    logic [PHYS_W-1:0]    free_pd;
    logic                 tail_restore_valid;
    logic [ROB_IDX_W-1:0] tail_restore;
    logic                 rename_stall;
    logic                 busy;

    modport master (
        input  mispredict_valid, mispredict_idx, rob_tail, flush_valid,
        input  rob_rd_uses_rd, rob_rd_arch, rob_rd_pd_old, rob_rd_pd_new,
        output rob_rd_idx, recover_valid, recover_rd_arch, recover_pd,
        output free_valid, free_pd, tail_restore_valid, tail_restore,
        output rename_stall, busy
    );

    modport slave (
        output mispredict_valid, mispredict_idx, rob_tail, flush_valid,
        output rob_rd_uses_rd, rob_rd_arch, rob_rd_pd_old, rob_rd_pd_new,
        input  rob_rd_idx, recover_valid, recover_rd_arch, recover_pd,
        input  free_valid, free_pd, tail_restore_valid, tail_restore,
        input  rename_stall, busy
    );
endinterface

// File: rtl/rat_recovery_walker.sv
// Branch-mispredict rollback sequencer: walks the squashed ROB entries youngest first,
// restoring RAT mappings and freeing tags, then pulses the restored ROB tail.
module rat_recovery_walker #(
    parameter int unsigned ROB_DEPTH = 32,
    parameter int unsigned ROB_IDX_W = $clog2(ROB_DEPTH),
    parameter int unsigned PHYS_REGS = 64,
    parameter int unsigned PHYS_W    = $clog2(PHYS_REGS)
) (
    input logic                  clk,
    input logic                  rst,
    rat_recovery_walker_if.master bus
);

    typedef enum logic [1:0] {IDLE, WALK, DRAIN, DONE} state_t;

    state_t               state_q, state_d;
    logic [ROB_IDX_W-1:0] walk_ptr_q;
    logic [ROB_IDX_W-1:0] count_q;
    logic [ROB_IDX_W-1:0] tail_q;
    logic [ROB_IDX_W-1:0] req_count;
    logic                 accept;
    logic                 rec_valid_q;
    logic [4:0]           rec_arch_q;
    logic [PHYS_W-1:0]    rec_pd_q;
    logic [PHYS_W-1:0]    free_pd_q;

    // Modular entry count; tail == idx wraps to a full ROB of ROB_DEPTH-1 entries.
    assign req_count = bus.rob_tail - bus.mispredict_idx - ROB_IDX_W'(1);
    assign accept    = (state_q == IDLE) && bus.mispredict_valid && !bus.flush_valid;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_valid) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:  if (bus.mispredict_valid) state_d = (req_count == '0) ? DONE : WALK;
                WALK:  if (count_q == ROB_IDX_W'(1)) state_d = DRAIN;
                DRAIN: state_d = DONE;
                DONE:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            walk_ptr_q  <= '0;
            count_q     <= '0;
            tail_q      <= '0;
            rec_valid_q <= 1'b0;
            rec_arch_q  <= '0;
            rec_pd_q    <= '0;
            free_pd_q   <= '0;
        end else begin
            if (accept) begin
                count_q    <= req_count;
                walk_ptr_q <= bus.rob_tail - ROB_IDX_W'(1);
                tail_q     <= bus.mispredict_idx + ROB_IDX_W'(1);
            end else if (state_q == WALK) begin
                count_q    <= count_q - ROB_IDX_W'(1);
                walk_ptr_q <= walk_ptr_q - ROB_IDX_W'(1);
            end
            rec_valid_q <= (state_q == WALK) && !bus.flush_valid &&
                           bus.rob_rd_uses_rd && (bus.rob_rd_arch != 5'd0);
            if (state_q == WALK) begin
                rec_arch_q <= bus.rob_rd_arch;
                rec_pd_q   <= bus.rob_rd_pd_old;
                free_pd_q  <= bus.rob_rd_pd_new;
            end
        end
    end

    // A flush masks the strobe already registered from the previous read, as well as later ones.
    assign bus.rob_rd_idx         = (state_q == WALK) ? walk_ptr_q : '0;
    assign bus.recover_valid      = rec_valid_q && !bus.flush_valid;
    assign bus.free_valid         = rec_valid_q && !bus.flush_valid;
    assign bus.recover_rd_arch    = rec_arch_q;
    assign bus.recover_pd         = rec_pd_q;
    assign bus.free_pd            = free_pd_q;
    assign bus.tail_restore_valid = (state_q == DONE) && !bus.flush_valid;
    assign bus.tail_restore       = tail_q;
    assign bus.busy               = (state_q != IDLE);
    assign bus.rename_stall       = (state_q != IDLE) || ((state_q == IDLE) && bus.mispredict_valid);

endmodule

// File: tb/tb_rat_recovery_walker.sv
// Directed bench for rat_recovery_walker: a small ROB array model answers reads, and every
// cycle of each scenario is checked against hand-computed expected outputs.
module tb_rat_recovery_walker;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic       m_uses [32];
    logic [4:0] m_arch [32];
    logic [5:0] m_old  [32];
    logic [5:0] m_new  [32];

    rat_recovery_walker_if #(.ROB_IDX_W(5), .PHYS_W(6)) bus ();

    rat_recovery_walker #(.ROB_DEPTH(32), .PHYS_REGS(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ROB read port answers in the same cycle as the address.
    always_comb begin
        bus.rob_rd_uses_rd = m_uses[bus.rob_rd_idx];
        bus.rob_rd_arch    = m_arch[bus.rob_rd_idx];
        bus.rob_rd_pd_old  = m_old[bus.rob_rd_idx];
        bus.rob_rd_pd_new  = m_new[bus.rob_rd_idx];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_ent(input int idx, input logic uses, input int arch, input int pold, input int pnew);
        m_uses[idx] = uses;
        m_arch[idx] = 5'(arch);
        m_old[idx]  = 6'(pold);
        m_new[idx]  = 6'(pnew);
    endtask

    // Check one cycle at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input int ridx, input int rv, input int rarch,
                       input int rpd, input int fpd, input int tv, input int tl,
                       input int stall, input int bsy);
        @(negedge clk);
        check({tag, "/rd_idx"}, 32'(bus.rob_rd_idx), ridx);
        check({tag, "/recover_valid"}, 32'(bus.recover_valid), rv);
        check({tag, "/free_valid"}, 32'(bus.free_valid), rv);
        if (rv != 0) begin
            check({tag, "/recover_arch"}, 32'(bus.recover_rd_arch), rarch);
            check({tag, "/recover_pd"}, 32'(bus.recover_pd), rpd);
            check({tag, "/free_pd"}, 32'(bus.free_pd), fpd);
        end
        check({tag, "/tail_valid"}, 32'(bus.tail_restore_valid), tv);
        if (tv != 0) check({tag, "/tail"}, 32'(bus.tail_restore), tl);
        check({tag, "/stall"}, 32'(bus.rename_stall), stall);
        check({tag, "/busy"}, 32'(bus.busy), bsy);
        @(posedge clk);
        #1;
    endtask

    task automatic request(input int idx, input int tail);
        bus.mispredict_valid = 1'b1;
        bus.mispredict_idx   = 5'(idx);
        bus.rob_tail         = 5'(tail);
    endtask

    task automatic release_req();
        bus.mispredict_valid = 1'b0;
        bus.mispredict_idx   = '0;
        bus.rob_tail         = '0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) set_ent(i, 1'b0, 0, 0, 0);
        rst = 1'b1;
        bus.flush_valid = 1'b0;
        release_req();
        repeat (2) @(posedge clk);
        #1;
        cyc("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset/tail", 32'(bus.tail_restore), 0);
        rst = 1'b0;
        cyc("post_reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Three younger entries, repeated x3 so the oldest pd_old lands last.
        set_ent(7, 1'b1, 3, 10, 40);
        set_ent(6, 1'b1, 5, 11, 41);
        set_ent(5, 1'b1, 3, 12, 42);
        request(4, 8);
        cyc("t1c0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        release_req();
        cyc("t1c1", 7, 0, 0, 0, 0, 0, 0, 1, 1);
        request(0, 20);  // ignored while busy
        cyc("t1c2", 6, 1, 3, 10, 40, 0, 0, 1, 1);
        release_req();
        cyc("t1c3", 5, 1, 5, 11, 41, 0, 0, 1, 1);
        cyc("t1c4", 0, 1, 3, 12, 42, 0, 0, 1, 1);
        cyc("t1c5", 0, 0, 0, 0, 0, 1, 5, 1, 1);
        cyc("t1c6", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // No younger entries.
        request(5, 6);
        cyc("t2c0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        release_req();
        cyc("t2c1", 0, 0, 0, 0, 0, 1, 6, 1, 1);
        cyc("t2c2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Index wrap 1,0,31.
        set_ent(1, 1'b1, 7, 20, 50);
        set_ent(0, 1'b1, 8, 21, 51);
        set_ent(31, 1'b1, 9, 22, 52);
        request(30, 2);
        cyc("t3c0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        release_req();
        cyc("t3c1", 1, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc("t3c2", 0, 1, 7, 20, 50, 0, 0, 1, 1);
        cyc("t3c3", 31, 1, 8, 21, 51, 0, 0, 1, 1);
        cyc("t3c4", 0, 1, 9, 22, 52, 0, 0, 1, 1);
        cyc("t3c5", 0, 0, 0, 0, 0, 1, 31, 1, 1);
        cyc("t3c6", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Entries without a real destination still take a cycle each.
        set_ent(14, 1'b0, 4, 1, 2);
        set_ent(13, 1'b1, 0, 3, 4);
        set_ent(12, 1'b1, 6, 13, 43);
        set_ent(11, 1'b0, 2, 5, 6);
        request(10, 15);
        cyc("t4c0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        release_req();
        cyc("t4c1", 14, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc("t4c2", 13, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc("t4c3", 12, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc("t4c4", 11, 1, 6, 13, 43, 0, 0, 1, 1);
        cyc("t4c5", 0, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc("t4c6", 0, 0, 0, 0, 0, 1, 11, 1, 1);
        cyc("t4c7", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Flush on the second walk cycle, then flush beating a simultaneous request.
        request(4, 8);
        cyc("t5c0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        release_req();
        cyc("t5c1", 7, 0, 0, 0, 0, 0, 0, 1, 1);
        bus.flush_valid = 1'b1;
        cyc("t5c2", 6, 0, 0, 0, 0, 0, 0, 1, 1);
        bus.flush_valid = 1'b0;
        cyc("t5c3", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5c4", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush_valid = 1'b1;
        request(4, 8);
        cyc("t5c5", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        bus.flush_valid = 1'b0;
        release_req();
        cyc("t5c6", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-walk, then a clean two-entry walk.
        request(4, 8);
        cyc("t6c0", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        release_req();
        cyc("t6c1", 7, 0, 0, 0, 0, 0, 0, 1, 1);
        rst = 1'b1;
        cyc("t6c2", 6, 1, 3, 10, 40, 0, 0, 1, 1);
        rst = 1'b0;
        cyc("t6c3", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6/tail_cleared", 32'(bus.tail_restore), 0);
        set_ent(2, 1'b1, 10, 30, 60);
        set_ent(1, 1'b1, 11, 31, 61);
        request(0, 3);
        cyc("t6c4", 0, 0, 0, 0, 0, 0, 0, 1, 0);
        release_req();
        cyc("t6c5", 2, 0, 0, 0, 0, 0, 0, 1, 1);
        cyc("t6c6", 1, 1, 10, 30, 60, 0, 0, 1, 1);
        cyc("t6c7", 0, 1, 11, 31, 61, 0, 0, 1, 1);
        cyc("t6c8", 0, 0, 0, 0, 0, 1, 1, 1, 1);
        cyc("t6c9", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
